// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side counterpart of the VGA video timer. Consumes active-low
// hsync/vsync and 4-bit RGB in the pixel-clock domain, recovers the pixel
// position from the sync edges, checks the sync timing against the expected
// mode and reports lock. Qualified pixels are delivered with their (x, y)
// coordinates for downstream capture and self-check logic.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   hsync_i        horizontal sync, active low
//   vsync_i        vertical sync, active low
//   r_i/g_i/b_i    4-bit input colour
//   locked_o       timing lock achieved
//   pixel_valid_o  output pixel is visible and the decoder is locked
//   pos_x_o        recovered x of the output pixel (10 bits)
//   pos_y_o        recovered y of the output pixel (9 bits)
//   pix_*_o        pixel colour, 0 when pixel_valid_o is low
//   frame_start_o  one-cycle pulse on the locked pixel (0,0)
//   frame_count_o  number of frame_start pulses, wrapping
//   h_err_o        one-cycle pulse on a horizontal timing mismatch
//   v_err_o        one-cycle pulse on a vertical timing mismatch
//
// Pin-to-output latency is two clocks: one input register stage (s1), which
// the counters and FSM decode, then one output register stage.
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  r_i,
  input  logic [3:0]  g_i,
  input  logic [3:0]  b_i,
  output logic        locked_o,
  output logic        pixel_valid_o,
  output logic [9:0]  pos_x_o,
  output logic [8:0]  pos_y_o,
  output logic [3:0]  pix_r_o,
  output logic [3:0]  pix_g_o,
  output logic [3:0]  pix_b_o,
  output logic        frame_start_o,
  output logic [15:0] frame_count_o,
  output logic        h_err_o,
  output logic        v_err_o
);

  localparam int WL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int WF = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // hsync falls at the first sync clock; the clock before it is the one the
  // counter must be on for the edge to be on time.
  localparam logic [9:0]  H_LOAD   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  H_EXPECT = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0]  H_LAST   = 10'(WL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_LOAD   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_EXPECT = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0]  V_LAST   = 10'(WF - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [10:0] TO_LAST  = 11'(2 * WL - 1);

  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGNED,
    LOCKED
  } state_e;

  // Input stage and edge history
  logic        hs1_q, vs1_q, hs_prev_q, vs_prev_q;
  logic [11:0] rgb1_q;

  // Timing recovery
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic [10:0]   to_q, to_d;
  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;

  // Output stage
  logic        locked_q, valid_q, fs_q, h_err_q, v_err_q;
  logic [9:0]  pos_x_q;
  logic [8:0]  pos_y_q;
  logic [11:0] pix_q;
  logic [15:0] frame_count_q;

  logic hs_fall, vs_fall, hwrap, v_good, h_err_d, v_err_d, timeout;
  logic valid_d, fs_d;

  assign hs_fall = !hs1_q && hs_prev_q;
  assign vs_fall = !vs1_q && vs_prev_q;

  // Counters, edge checks and timeout. hcount_d/vcount_d are the position of
  // the pixel currently held in s1.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    hwrap    = 1'b0;
    hcount_d = hcount_q + 10'd1;
    if (hs_fall) begin
      hcount_d = H_LOAD;
    end else if (hcount_q == H_LAST) begin
      hcount_d = '0;
      hwrap    = 1'b1;
    end

    vcount_d = vcount_q;
    if (vs_fall) begin
      vcount_d = V_LOAD;
    end else if (hwrap) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end

    // The vsync fall is only on time when it coincides with the line wrap
    // that would take vcount onto its load value anyway.
    v_good  = vs_fall && hwrap && (vcount_q == V_EXPECT);
    v_err_d = (vs_fall && !v_good) || (hwrap && (vcount_q == V_EXPECT) && !vs_fall);
    // The first fall seen while searching defines the alignment, so it is
    // never an error.
    h_err_d = hs_fall && (state_q != SEARCH) && (hcount_q != H_EXPECT);

    // A fall on the same cycle as the timeout wins.
    timeout = !hs_fall && (to_q == TO_LAST);
    to_d    = (hs_fall || timeout) ? '0 : to_q + 11'd1;
  end

  // Lock FSM
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEARCH: begin
        if (hs_fall) begin
          state_d = H_ALIGNED;
          good_d  = '0;
        end
      end
      H_ALIGNED: begin
        // An error on the lock-completing frame takes priority over the lock.
        if (h_err_d || v_err_d) begin
          good_d = '0;
        end else if (v_good) begin
          if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (h_err_d || v_err_d) begin
          state_d = H_ALIGNED;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
    if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  // Lock and qualification use the next state so that locked, errors and
  // pixels all leave the output stage with the same two-clock latency.
  assign valid_d = (state_d == LOCKED) && (hcount_d < H_VIS) && (vcount_d < V_VIS);
  assign fs_d    = valid_d && (hcount_d == '0) && (vcount_d == '0);

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values of the others, matching the hardware.
    if (rst) begin
      // NOTE: reset lands on every flop here, including the output stage,
      // because all outputs must read zero the cycle after reset.
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      rgb1_q        <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      to_q          <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      locked_q      <= 1'b0;
      valid_q       <= 1'b0;
      fs_q          <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      pix_q         <= '0;
      frame_count_q <= '0;
    end else begin
      hs1_q         <= hsync_i;
      vs1_q         <= vsync_i;
      hs_prev_q     <= hs1_q;
      vs_prev_q     <= vs1_q;
      rgb1_q        <= {r_i, g_i, b_i};
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      to_q          <= to_d;
      state_q       <= state_d;
      good_q        <= good_d;
      locked_q      <= (state_d == LOCKED);
      valid_q       <= valid_d;
      fs_q          <= fs_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      pos_x_q       <= hcount_d;
      pos_y_q       <= vcount_d[8:0];
      pix_q         <= valid_d ? rgb1_q : '0;
      if (fs_d) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign locked_o      = locked_q;
  assign pixel_valid_o = valid_q;
  assign pos_x_o       = pos_x_q;
  assign pos_y_o       = pos_y_q;
  assign pix_r_o       = pix_q[11:8];
  assign pix_g_o       = pix_q[7:4];
  assign pix_b_o       = pix_q[3:0];
  assign frame_start_o = fs_q;
  assign frame_count_o = frame_count_q;
  assign h_err_o       = h_err_q;
  assign v_err_o       = v_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives vga_sync_decoder from a behavioural video timer running a reduced
// mode (32 clocks x 15 lines) so that many frames fit in a short run.
// Output at the negedge after drive step k reflects the pins of step k-2.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HV = 16, HF = 4, HS = 8, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LF = 2;
  localparam int WL = HV + HF + HS + HB;   // 32
  localparam int WF = VV + VF + VS + VB;   // 15
  localparam int FRAME = WL * WF;          // 480

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_i = 1'b1, vsync_i = 1'b1;
  logic [3:0]  r_i = '0, g_i = '0, b_i = '0;
  logic        locked_o, pixel_valid_o, frame_start_o, h_err_o, v_err_o;
  logic [9:0]  pos_x_o;
  logic [8:0]  pos_y_o;
  logic [3:0]  pix_r_o, pix_g_o, pix_b_o;
  logic [15:0] frame_count_o;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .r_i          (r_i),
    .g_i          (g_i),
    .b_i          (b_i),
    .locked_o     (locked_o),
    .pixel_valid_o(pixel_valid_o),
    .pos_x_o      (pos_x_o),
    .pos_y_o      (pos_y_o),
    .pix_r_o      (pix_r_o),
    .pix_g_o      (pix_g_o),
    .pix_b_o      (pix_b_o),
    .frame_start_o(frame_start_o),
    .frame_count_o(frame_count_o),
    .h_err_o      (h_err_o),
    .v_err_o      (v_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        exp_valid;
    logic [9:0]  exp_x;
    logic [8:0]  exp_y;
    logic [11:0] exp_pix;
    logic        exp_fs;
  } vec_t;

  vec_t vecs[10];

  int n_vec = 0, n_bad = 0;
  int gh = 0, gv = 0;            // next pixel the timer will drive
  int step_n = 0;
  int herr_seen = 0, verr_seen = 0;
  bit hs_force_high = 1'b0;
  int vs_delay = 0;
  int vfalls = 0, vfall2_step = -1, lock_step = -1;
  int fs_step = -1, fs_x = -1, fs_y = -1;
  logic [15:0] fs_cnt;
  logic        fs_valid;
  int hx[3] = '{0, 0, 0};
  int hy[3] = '{0, 0, 0};
  int pend[3] = '{-1, -1, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One pixel clock of the timer: drive pins just after the edge, then sample
  // the decoder outputs on the falling edge.
  task automatic step(input bit use_rgb, input logic [11:0] rgb, input int vi);
    logic hs, vs;
    int   p;
    @(posedge clk);
    #1;
    p  = gv * WL + gh;
    hs = hs_force_high || !(gh >= HV + HF && gh < HV + HF + HS);
    vs = !(p >= (VV + VF) * WL + vs_delay && p < (VV + VF + VS) * WL + vs_delay);
    step_n++;
    if (vsync_i && !vs) begin
      vfalls++;
      if (vfalls == 2) vfall2_step = step_n;
    end
    hsync_i = hs;
    vsync_i = vs;
    {r_i, g_i, b_i} = use_rgb ? rgb : {4'(gh), 4'(gv), 4'h3};
    hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = gh;
    hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = gv;
    pend[2] = pend[1]; pend[1] = pend[0]; pend[0] = vi;
    gh++;
    if (gh == WL) begin
      gh = 0;
      gv++;
      if (gv == WF) gv = 0;
    end
    @(negedge clk);
    herr_seen += int'(h_err_o);
    verr_seen += int'(v_err_o);
    if (locked_o && lock_step < 0) lock_step = step_n;
    if (frame_start_o && fs_step < 0) begin
      fs_step  = step_n;
      fs_x     = hx[2];
      fs_y     = hy[2];
      fs_cnt   = frame_count_o;
      fs_valid = pixel_valid_o;
    end
    if (pend[2] >= 0) begin
      vec_t v;
      v = vecs[pend[2]];
      check($sformatf("vec%0d valid", pend[2]), pixel_valid_o, v.exp_valid);
      check($sformatf("vec%0d pos_x", pend[2]), pos_x_o, v.exp_x);
      check($sformatf("vec%0d pos_y", pend[2]), pos_y_o, v.exp_y);
      check($sformatf("vec%0d pix", pend[2]), {pix_r_o, pix_g_o, pix_b_o}, v.exp_pix);
      check($sformatf("vec%0d frame_start", pend[2]), frame_start_o, v.exp_fs);
    end
  endtask

  task automatic run_until(input int x, input int y);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (gh == x && gv == y) break;
      step(1'b0, 12'h000, -1);
    end
  endtask

  task automatic wait_lock(input string name, input int max_steps);
    for (int i = 0; i < max_steps; i++) begin
      if (locked_o) break;
      step(1'b0, 12'h000, -1);
    end
    check(name, locked_o, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           x   y   rgb      valid  px  py  pix      fs
    vecs[0] = '{ 0,  0, 12'hF0A, 1'b1,  0,  0, 12'hF0A, 1'b1};
    vecs[1] = '{15,  0, 12'h123, 1'b1, 15,  0, 12'h123, 1'b0};
    vecs[2] = '{16,  0, 12'h777, 1'b0, 16,  0, 12'h000, 1'b0};
    vecs[3] = '{31,  0, 12'h999, 1'b0, 31,  0, 12'h000, 1'b0};
    vecs[4] = '{ 5,  3, 12'h842, 1'b1,  5,  3, 12'h842, 1'b0};
    vecs[5] = '{ 0,  7, 12'hCBA, 1'b1,  0,  7, 12'hCBA, 1'b0};
    vecs[6] = '{15,  7, 12'h456, 1'b1, 15,  7, 12'h456, 1'b0};
    vecs[7] = '{ 0,  8, 12'h111, 1'b0,  0,  8, 12'h000, 1'b0};
    vecs[8] = '{20, 10, 12'h333, 1'b0, 20, 10, 12'h000, 1'b0};
    vecs[9] = '{31, 14, 12'hEEE, 1'b0, 31, 14, 12'h000, 1'b0};

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset locked", locked_o, 1'b0);
    check("reset pixel_valid", pixel_valid_o, 1'b0);
    check("reset pos", {pos_x_o, pos_y_o}, 19'h0);
    check("reset pix", {pix_r_o, pix_g_o, pix_b_o}, 12'h000);
    check("reset frame_count", frame_count_o, 16'h0);
    check("reset errs", {h_err_o, v_err_o, frame_start_o}, 3'b000);
    rst = 1'b0;

    // ---- loopback from reset: lock after 2nd vsync, then first frame_start
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (fs_step >= 0) break;
      step(1'b0, 12'h000, -1);
    end
    check("loopback h_err count", herr_seen, 0);
    check("loopback v_err count", verr_seen, 0);
    check("lock latency from 2nd vsync fall", lock_step - vfall2_step, 2);
    check("first frame_start x", fs_x, 0);
    check("first frame_start y", fs_y, 0);
    check("first frame_count", fs_cnt, 16'd1);
    check("first frame_start valid", fs_valid, 1'b1);

    // ---- table vectors while locked
    herr_seen = 0;
    verr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      run_until(vecs[i].x, vecs[i].y);
      step(1'b1, vecs[i].rgb, i);
    end
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);
    check("vectors h_err count", herr_seen, 0);
    check("vectors v_err count", verr_seen, 0);
    check("vectors still locked", locked_o, 1'b1);

    // ---- hsync fall 4 clocks early (line shortened)
    herr_seen = 0;
    verr_seen = 0;
    run_until(HV, 2);
    gh = HV + HF;
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);
    check("early hsync pos_x", pos_x_o, 10'(HV + HF));
    check("early hsync pos_y", pos_y_o, 9'd2);
    check("early hsync h_err", h_err_o, 1'b1);
    check("early hsync locked", locked_o, 1'b0);
    wait_lock("early hsync relock", 4 * FRAME);
    check("early hsync h_err count", herr_seen, 1);
    check("early hsync v_err count", verr_seen, 0);

    // ---- vsync fall delayed 5 clocks for one frame
    run_until(0, 0);
    herr_seen = 0;
    verr_seen = 0;
    vs_delay  = 5;
    run_until(8, VV + VF);
    check("late vsync v_err", v_err_o, 1'b1);
    check("late vsync locked", locked_o, 1'b0);
    run_until(0, VV + VF + VS + 1);
    vs_delay = 0;
    check("late vsync v_err count", verr_seen, 2);
    wait_lock("late vsync relock", 4 * FRAME);
    check("late vsync h_err count", herr_seen, 0);

    // ---- hsync held high past the timeout
    herr_seen = 0;
    run_until(HV + HF + HS, 1);
    hs_force_high = 1'b1;
    run_until(8, 5);
    check("timeout locked", locked_o, 1'b0);
    check("timeout pixel_valid", pixel_valid_o, 1'b0);
    run_until(HV + HF + HS, 5);
    hs_force_high = 1'b0;
    run_until(0, 7);
    check("timeout first fall h_err count", herr_seen, 0);
    check("timeout not yet relocked", locked_o, 1'b0);
    wait_lock("timeout relock", 4 * FRAME);

    // ---- synchronous reset mid-frame while locked
    run_until(8, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset locked", locked_o, 1'b0);
    check("midreset pixel_valid", pixel_valid_o, 1'b0);
    check("midreset pos", {pos_x_o, pos_y_o}, 19'h0);
    check("midreset pix", {pix_r_o, pix_g_o, pix_b_o}, 12'h000);
    check("midreset frame_count", frame_count_o, 16'h0);
    check("midreset pulses", {h_err_o, v_err_o, frame_start_o}, 3'b000);
    rst = 1'b0;
    repeat (WL) step(1'b0, 12'h000, -1);
    check("post-reset searching", locked_o, 1'b0);
    fs_step = -1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (fs_step >= 0) break;
      step(1'b0, 12'h000, -1);
    end
    check("post-reset relocked", locked_o, 1'b1);
    check("post-reset frame_count", fs_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA video timer: consumes active-low hsync/vsync plus 4-bit RGB in the pixel-clock domain.
- Recovers the pixel position, checks the sync timing against the expected mode, and reports lock.
- Delivers qualified pixels with (x, y) coordinates to downstream capture and self-check logic.
- Used in loopback benches and as an on-chip monitor of the generated video stream.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- LOCK_FRAMES, 2, consecutive error-free frames required before locked asserts

Ports:
- clk  in  1  pixel clock (25.175 MHz)
- rst  in  1  reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- r, g, b  in  4 each  input colour
- locked  out  1  timing lock achieved
- pixel_valid  out  1  output pixel is in the visible area and locked=1
- pos_x  out  10  recovered x of output pixel
- pos_y  out  9  recovered y of output pixel
- pix_r, pix_g, pix_b  out  4 each  pixel colour; 0 when pixel_valid=0
- frame_start  out  1  one-cycle pulse on the locked pixel (0,0)
- frame_count  out  16  count of frame_start pulses, wraps at 0xFFFF->0
- h_err  out  1  one-cycle pulse on a horizontal timing mismatch
- v_err  out  1  one-cycle pulse on a vertical timing mismatch

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset all outputs are 0, the FSM enters SEARCH, all counters clear, and the input registers load hsync=1, vsync=1, rgb=0.
- Input stage s1: hsync, vsync and rgb are registered once. Edge detection is performed on s1 against its previous value (hs_prev).
- Constants: WL = sum of the four H parameters (800). WF = sum of the four V parameters (525).
- hcount: 10 bits.
  - An hsync fall (hs1=0, hs_prev=1) loads H_VISIBLE+H_FRONT (656).
  - Otherwise hcount increments, wrapping WL-1 -> 0.
  - h_err pulses if a fall arrives while hcount != 655, i.e. the fall was unexpected. The first fall seen in SEARCH is exempt.
- vcount: 10 bits; increments on each hcount wrap, wrapping WF-1 -> 0.
  - A vsync fall loads V_VISIBLE+V_FRONT (490).
  - The fall is expected on the cycle where hcount wraps to 0 with vcount = 489.
  - v_err pulses on any other fall position, or if vcount reaches 490 with no fall present.
- FSM states:
  - SEARCH: waiting for an hsync fall; goes to H_ALIGNED on the first fall.
  - H_ALIGNED: counting good frames. A good vsync fall with good_frames = LOCK_FRAMES-1 moves to LOCKED. A good fall otherwise increments good_frames.
  - LOCKED: any h_err or v_err returns to H_ALIGNED with good_frames=0. The counters realign to the offending edge.
- Any h_err or v_err in H_ALIGNED clears good_frames.
- Timeout: 11-bit counter clears on each hsync fall. Reaching 2*WL (1600) forces SEARCH from any state, clears good_frames, and sets locked=0.
- Output stage (registered from s1): end-to-end latency is 2 clocks, pin to output.
  - pixel_valid = LOCKED && hcount < H_VISIBLE && vcount < V_VISIBLE.
  - pos_x = hcount, and pos_y = vcount truncated to 9 bits; these update in all states.
  - pix_* = rgb1 when valid, else 0.
  - locked, h_err and v_err share the same 2-clock latency.
- frame_start = pixel_valid with hcount=0 and vcount=0. frame_count increments on the same cycle frame_start is seen.
- Simultaneous events:
  - An hsync fall and a timeout on the same cycle: the fall wins.
  - An error on the same cycle as the LOCK_FRAMES-th good vsync: the error wins and there is no lock.

Test Plan:
- Loopback from a 640x480 timer after both leave reset together:
  - h_err=0 and v_err=0 throughout.
  - locked rises 2 clocks after the 2nd vsync pin fall.
  - The first frame_start follows at the next (0,0), with frame_count=1.
- Locked, drive rgb=(F,0,A) at generator pixel (0,0):
  - 2 clocks later: pos_x=0, pos_y=0, pix=(F,0,A), pixel_valid=1, frame_start=1.
  - At generator x=640: pixel_valid=0 and pix=0.
- Locked, one hsync fall 4 clocks early:
  - h_err pulses once and locked falls.
  - pos_x is 656 at the shifted edge.
  - Relocks after 2 clean frames.
- Locked, vsync fall delayed 5 clocks:
  - v_err pulses and locked=0.
  - The clean frames that follow relock.
- hsync held high for 1600 clocks: FSM in SEARCH, locked=0, pixel_valid=0. A later hsync fall produces no h_err.
- rst asserted mid-frame while locked: next cycle all outputs are 0 and frame_count=0. After rst deasserts, locking restarts from SEARCH.
